// File: rtl/sdram_burst_tester.sv
// SDRAM self-test sequencer: write pattern bursts over a region, read back, compare, report.
// Optional watchdog abort when SDRAM_BURST_TESTER_TIMEOUT_EN is defined.
module sdram_burst_tester #(
    parameter int         C_addr_bits = 23,
    parameter int         C_data_bits = 16,
    parameter int         C_wr_words  = 128,
    parameter logic [1:0] C_rd_cmd    = 2'b11,
    parameter int         C_bursts    = 4,
    parameter int         C_timeout   = 4095
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [15:0]            seed,
    input  logic [C_addr_bits-1:0] base_addr,
    output logic [1:0]             sys_cmd,
    output logic [C_addr_bits-1:0] sys_addr,
    output logic [C_data_bits-1:0] sys_din,
    input  logic [C_data_bits-1:0] sys_dout,
    input  logic                   sys_wr_data_valid,
    input  logic                   sys_rd_data_valid,
    input  logic [1:0]             sys_cmd_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_count,
    output logic [C_addr_bits-1:0] first_err_addr,
    output logic [C_data_bits-1:0] first_err_exp,
    output logic [C_data_bits-1:0] first_err_got,
    output logic                   timeout
);

    localparam int C_rd_words  = (C_rd_cmd == 2'b10) ? 16 : 128;
    localparam int C_rd_bursts = C_bursts * C_wr_words / C_rd_words;
    localparam logic [C_addr_bits-1:0] C_wr_step = C_addr_bits'(C_wr_words);
    localparam logic [C_addr_bits-1:0] C_rd_step = C_addr_bits'(C_rd_words);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA, S_FIN
    } state_t;

    state_t                 r_state, w_next;
    logic [1:0]             r_mode;
    logic [15:0]            r_seed, r_idx, r_lfsr, r_beat, r_bcnt, r_err_cnt;
    logic [C_addr_bits-1:0] r_base, r_burst_addr, r_fe_addr;
    logic [C_data_bits-1:0] r_fe_exp, r_fe_got;
    logic                   r_busy, r_done, r_pass, r_timeout;

    logic [C_addr_bits-1:0] w_waddr;
    logic [15:0]            w_pat16, w_lfsr_nxt, w_lfsr_seed_in, w_lfsr_seed_r;
    logic [C_data_bits-1:0] w_pat;
    logic                   w_wr_last, w_wr_blast, w_rd_last, w_rd_blast, w_wd_hit;

    assign w_waddr        = r_burst_addr + C_addr_bits'(r_beat);
    assign w_lfsr_nxt     = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_lfsr_seed_in = (seed == 16'h0000) ? 16'h0001 : seed;
    assign w_lfsr_seed_r  = (r_seed == 16'h0000) ? 16'h0001 : r_seed;
    assign w_wr_last      = (r_beat == 16'(C_wr_words - 1));
    assign w_wr_blast     = (r_bcnt == 16'(C_bursts - 1));
    assign w_rd_last      = (r_beat == 16'(C_rd_words - 1));
    assign w_rd_blast     = (r_bcnt == 16'(C_rd_bursts - 1));

    always_comb begin
        case (r_mode)
            2'd0:    w_pat16 = r_seed + r_idx;
            2'd1:    w_pat16 = r_lfsr;
            2'd2:    w_pat16 = 16'(w_waddr);
            default: w_pat16 = ~16'(w_waddr);
        endcase
    end
    assign w_pat = C_data_bits'(w_pat16);

`ifdef SDRAM_BURST_TESTER_TIMEOUT_EN
    localparam int C_wd_bits = $clog2(C_timeout + 1);
    logic [C_wd_bits-1:0] r_wd;

    // Any handshake activity from the controller proves it is alive.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wd <= '0;
        end else if (r_state == S_IDLE || r_state == S_FIN || sys_cmd_ack != 2'b00 ||
                     sys_wr_data_valid || sys_rd_data_valid) begin
            r_wd <= '0;
        end else if (r_wd != C_wd_bits'(C_timeout)) begin
            r_wd <= r_wd + 1'b1;
        end
    end
    assign w_wd_hit = (r_state != S_IDLE) && (r_state != S_FIN) && (r_wd == C_wd_bits'(C_timeout));
`else
    assign w_wd_hit = 1'b0 && (C_timeout > 0);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        sys_cmd = 2'b00;
        sys_din = '0;
        case (r_state)
            S_IDLE:    if (start) w_next = S_WR_CMD;
            S_WR_CMD: begin
                sys_cmd = 2'b01;
                if (sys_cmd_ack == 2'b01) w_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                sys_din = w_pat;
                if (sys_wr_data_valid && w_wr_last) w_next = w_wr_blast ? S_RD_CMD : S_WR_CMD;
            end
            S_RD_CMD: begin
                sys_cmd = C_rd_cmd;
                if (sys_cmd_ack == C_rd_cmd) w_next = S_RD_DATA;
            end
            S_RD_DATA: if (sys_rd_data_valid && w_rd_last) w_next = w_rd_blast ? S_FIN : S_RD_CMD;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_wd_hit) w_next = S_FIN;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mode       <= 2'd0;
            r_seed       <= '0;
            r_idx        <= '0;
            r_lfsr       <= '0;
            r_beat       <= '0;
            r_bcnt       <= '0;
            r_err_cnt    <= '0;
            r_base       <= '0;
            r_burst_addr <= '0;
            r_fe_addr    <= '0;
            r_fe_exp     <= '0;
            r_fe_got     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_mode       <= mode;
                    r_seed       <= seed;
                    r_base       <= base_addr;
                    r_burst_addr <= base_addr;
                    r_idx        <= '0;
                    r_lfsr       <= w_lfsr_seed_in;
                    r_beat       <= '0;
                    r_bcnt       <= '0;
                    r_err_cnt    <= '0;
                    r_fe_addr    <= '0;
                    r_fe_exp     <= '0;
                    r_fe_got     <= '0;
                    r_done       <= 1'b0;
                    r_pass       <= 1'b0;
                    r_timeout    <= 1'b0;
                    r_busy       <= 1'b1;
                end
                S_WR_DATA: if (sys_wr_data_valid) begin
                    r_idx  <= r_idx + 16'd1;
                    r_lfsr <= w_lfsr_nxt;
                    if (w_wr_last) begin
                        r_beat <= '0;
                        // Read phase replays the identical sequence from the region start.
                        if (w_wr_blast) begin
                            r_bcnt       <= '0;
                            r_burst_addr <= r_base;
                            r_idx        <= '0;
                            r_lfsr       <= w_lfsr_seed_r;
                        end else begin
                            r_bcnt       <= r_bcnt + 16'd1;
                            r_burst_addr <= r_burst_addr + C_wr_step;
                        end
                    end else begin
                        r_beat <= r_beat + 16'd1;
                    end
                end
                S_RD_DATA: if (sys_rd_data_valid) begin
                    if (sys_dout != w_pat) begin
                        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                        if (r_err_cnt == 16'h0000) begin
                            r_fe_addr <= w_waddr;
                            r_fe_exp  <= w_pat;
                            r_fe_got  <= sys_dout;
                        end
                    end
                    r_idx  <= r_idx + 16'd1;
                    r_lfsr <= w_lfsr_nxt;
                    if (w_rd_last) begin
                        r_beat       <= '0;
                        r_bcnt       <= w_rd_blast ? 16'd0 : r_bcnt + 16'd1;
                        r_burst_addr <= r_burst_addr + C_rd_step;
                    end else begin
                        r_beat <= r_beat + 16'd1;
                    end
                end
                S_FIN: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (r_err_cnt == 16'h0000) && !r_timeout;
                end
                default: ;
            endcase
            if (w_wd_hit) r_timeout <= 1'b1;
        end
    end

    assign sys_addr       = r_burst_addr;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_cnt;
    assign first_err_addr = r_fe_addr;
    assign first_err_exp  = r_fe_exp;
    assign first_err_got  = r_fe_got;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_sdram_burst_tester.sv
// Bench for sdram_burst_tester: two instances (128-word and 16-word read bursts) behind a
// shared behavioural controller model with 3-cycle ack latency and data-valid gaps.
module tb_sdram_burst_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [1:0]  cmd    [2];
    logic [22:0] addr   [2];
    logic [15:0] din    [2];
    logic [15:0] dout   [2];
    logic        wrv    [2];
    logic        rdv    [2];
    logic [1:0]  ack    [2];
    logic        start_s[2];
    logic [1:0]  mode_s [2];
    logic [15:0] seed_s [2];
    logic [22:0] base_s [2];
    logic        busy   [2];
    logic        done   [2];
    logic        pass   [2];
    logic [15:0] errc   [2];
    logic [22:0] fea    [2];
    logic [15:0] fee    [2];
    logic [15:0] feg    [2];
    logic        tmo    [2];

    sdram_burst_tester #(.C_rd_cmd(2'b11)) u_a (
        .clk(clk), .resetn(resetn), .start(start_s[0]), .mode(mode_s[0]), .seed(seed_s[0]),
        .base_addr(base_s[0]), .sys_cmd(cmd[0]), .sys_addr(addr[0]), .sys_din(din[0]),
        .sys_dout(dout[0]), .sys_wr_data_valid(wrv[0]), .sys_rd_data_valid(rdv[0]),
        .sys_cmd_ack(ack[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_err_addr(fea[0]), .first_err_exp(fee[0]),
        .first_err_got(feg[0]), .timeout(tmo[0]));

    sdram_burst_tester #(.C_rd_cmd(2'b10)) u_b (
        .clk(clk), .resetn(resetn), .start(start_s[1]), .mode(mode_s[1]), .seed(seed_s[1]),
        .base_addr(base_s[1]), .sys_cmd(cmd[1]), .sys_addr(addr[1]), .sys_din(din[1]),
        .sys_dout(dout[1]), .sys_wr_data_valid(wrv[1]), .sys_rd_data_valid(rdv[1]),
        .sys_cmd_ack(ack[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_err_addr(fea[1]), .first_err_exp(fee[1]),
        .first_err_got(feg[1]), .timeout(tmo[1]));

    // ---------------- controller model (drives on negedge) ----------------
    logic [15:0] mem [int];
    logic [15:0] wlog[$];
    logic [22:0] wcmd[$];
    logic [22:0] rcmd[$];
    bit          noack [2];
    bit          cor_en;
    logic [22:0] cor_addr;
    int          hold_err = 0;
    int          cyc = 0;
    int          ph  [2];
    int          wt  [2];
    int          bi  [2];
    int          blen[2];
    logic [1:0]  ccmd [2];
    logic [22:0] caddr[2];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                ph[k] = 0; ack[k] = 2'b00; wrv[k] = 1'b0; rdv[k] = 1'b0; dout[k] = 16'h0;
            end else begin
                case (ph[k])
                    0: begin
                        ack[k] = 2'b00; wrv[k] = 1'b0; rdv[k] = 1'b0;
                        if (cmd[k] != 2'b00 && !noack[k]) begin
                            ph[k] = 1; wt[k] = 3; ccmd[k] = cmd[k]; caddr[k] = addr[k];
                            if (cmd[k] == 2'b01) wcmd.push_back(addr[k]);
                            else                 rcmd.push_back(addr[k]);
                        end
                    end
                    1: begin
                        if (cmd[k] != ccmd[k] || addr[k] != caddr[k]) hold_err++;
                        ack[k] = 2'b00; wrv[k] = 1'b0; rdv[k] = 1'b0;
                        if (wt[k] == 2) begin
                            ack[k] = ccmd[k] ^ 2'b11; wrv[k] = 1'b1; rdv[k] = 1'b1;
                        end
                        if (wt[k] == 0) begin
                            ack[k] = ccmd[k]; ph[k] = 2; bi[k] = 0;
                            blen[k] = (ccmd[k] == 2'b10) ? 16 : 128;
                        end else begin
                            wt[k]--;
                        end
                    end
                    default: begin
                        ack[k] = 2'b00; wrv[k] = 1'b0; rdv[k] = 1'b0;
                        if (bi[k] == blen[k]) begin
                            ph[k] = 0;
                        end else if ((cyc % 5) != 3) begin
                            logic [22:0] a;
                            int          key;
                            a   = caddr[k] + 23'(bi[k]);
                            key = (k << 23) | int'(a);
                            if (ccmd[k] == 2'b01) begin
                                wrv[k]   = 1'b1;
                                mem[key] = din[k];
                                wlog.push_back(din[k]);
                            end else begin
                                rdv[k]  = 1'b1;
                                dout[k] = mem.exists(key) ? mem[key] : 16'hDEAD;
                                if (cor_en && a == cor_addr) dout[k] = dout[k] ^ 16'h0004;
                            end
                            bi[k]++;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic pulse_start(input int k, input logic [1:0] m, input logic [15:0] s,
                               input logic [22:0] b);
        @(negedge clk);
        mode_s[k] = m; seed_s[k] = s; base_s[k] = b; start_s[k] = 1'b1;
        @(negedge clk);
        // Scramble the inputs after the start cycle; the DUT must have latched them.
        start_s[k] = 1'b0; mode_s[k] = ~m; seed_s[k] = ~s; base_s[k] = ~b;
    endtask

    task automatic wait_done(input int k, output int n);
        n = 0;
        while (!done[k] && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    typedef struct {
        int          k;
        logic [1:0]  mode;
        logic [15:0] seed;
        logic [22:0] base;
        bit          cor;
        logic [22:0] cor_a;
        logic [15:0] e_err;
        bit          e_pass;
        logic [22:0] e_fa;
        logic [15:0] e_fe;
        logic [15:0] e_fg;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n, bad;
        logic [15:0] ref_w;
        vt[0] = '{0, 2'd0, 16'h1000, 23'h000000, 0, 23'h0,     16'd0, 1, 23'h0,     16'h0000, 16'h0000};
        vt[1] = '{0, 2'd2, 16'h0000, 23'h000000, 1, 23'h85,    16'd1, 0, 23'h85,    16'h0085, 16'h0081};
        vt[2] = '{1, 2'd0, 16'h1000, 23'h000000, 0, 23'h0,     16'd0, 1, 23'h0,     16'h0000, 16'h0000};
        vt[3] = '{0, 2'd3, 16'h0000, 23'h000100, 1, 23'h1C0,   16'd1, 0, 23'h1C0,   16'hFE3F, 16'hFE3B};
        vt[4] = '{0, 2'd1, 16'h0000, 23'h000200, 1, 23'h200,   16'd1, 0, 23'h200,   16'h0001, 16'h0005};
        vt[5] = '{0, 2'd2, 16'h0000, 23'h7FFF80, 1, 23'h3,     16'd1, 0, 23'h3,     16'h0003, 16'h0007};
        vt[6] = '{1, 2'd1, 16'hACE1, 23'h000040, 0, 23'h0,     16'd0, 1, 23'h0,     16'h0000, 16'h0000};

        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; mode_s[k] = 2'd0; seed_s[k] = 16'h0; base_s[k] = 23'h0;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd",     32'(cmd[0]),  32'd0);
        chk("rst_addr",    32'(addr[0]), 32'd0);
        chk("rst_din",     32'(din[0]),  32'd0);
        chk("rst_busy",    32'(busy[0]), 32'd0);
        chk("rst_done",    32'(done[0]), 32'd0);
        chk("rst_pass",    32'(pass[0]), 32'd0);
        chk("rst_err",     32'(errc[0]), 32'd0);
        chk("rst_fea",     32'(fea[0]),  32'd0);
        chk("rst_fee",     32'(fee[0]),  32'd0);
        chk("rst_feg",     32'(feg[0]),  32'd0);
        chk("rst_timeout", 32'(tmo[0]),  32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            wlog.delete(); wcmd.delete(); rcmd.delete();
            cor_en = vt[i].cor; cor_addr = vt[i].cor_a;
            pulse_start(vt[i].k, vt[i].mode, vt[i].seed, vt[i].base);
            chk("busy_run", 32'(busy[vt[i].k]), 32'd1);
            wait_done(vt[i].k, n);
            chk("done",     32'(done[vt[i].k]), 32'd1);
            chk("pass",     32'(pass[vt[i].k]), 32'(vt[i].e_pass));
            chk("err_cnt",  32'(errc[vt[i].k]), 32'(vt[i].e_err));
            chk("fe_addr",  32'(fea[vt[i].k]),  32'(vt[i].e_fa));
            chk("fe_exp",   32'(fee[vt[i].k]),  32'(vt[i].e_fe));
            chk("fe_got",   32'(feg[vt[i].k]),  32'(vt[i].e_fg));
            chk("busy_end", 32'(busy[vt[i].k]), 32'd0);
            chk("timeout0", 32'(tmo[vt[i].k]),  32'd0);
            chk("wr_words", 32'(wlog.size()),   32'd512);
            if (i == 0) begin
                bad = 0;
                foreach (wlog[j]) if (wlog[j] != 16'(32'h1000 + j)) bad++;
                chk("cnt_pattern_bad", 32'(bad), 32'd0);
                chk("wr_cmds", 32'(wcmd.size()), 32'd4);
                for (int j = 0; j < 4 && j < wcmd.size(); j++)
                    chk("wr_addr", 32'(wcmd[j]), 32'(j * 128));
            end
            if (i == 2) begin
                chk("rd_cmds16", 32'(rcmd.size()), 32'd32);
                bad = 0;
                foreach (rcmd[j]) if (rcmd[j] != 23'(j * 16)) bad++;
                chk("rd_addr16_bad", 32'(bad), 32'd0);
            end
            if (i == 5) begin
                chk("wrap_cmds", 32'(wcmd.size()), 32'd4);
                if (wcmd.size() >= 2) begin
                    chk("wrap_addr0", 32'(wcmd[0]), 32'h7FFF80);
                    chk("wrap_addr1", 32'(wcmd[1]), 32'h000000);
                end
            end
            if (i == 6) begin
                bad = 0;
                ref_w = 16'hACE1;
                foreach (wlog[j]) begin
                    if (wlog[j] != ref_w) bad++;
                    ref_w = lfsr_next(ref_w);
                end
                chk("lfsr_pattern_bad", 32'(bad), 32'd0);
            end
        end

        // start while busy is ignored; reset during WR_DATA aborts; a fresh run passes
        wlog.delete(); cor_en = 0;
        pulse_start(0, 2'd0, 16'h1000, 23'h0);
        n = 0;
        while (wlog.size() < 10 && n < 500) begin @(negedge clk); n++; end
        pulse_start(0, 2'd2, 16'h5555, 23'h40);
        n = 0;
        while (wlog.size() < 20 && n < 500) begin @(negedge clk); n++; end
        chk("wr_progress", 32'(wlog.size() >= 20), 32'd1);
        bad = 0;
        for (int j = 0; j < 20 && j < wlog.size(); j++) if (wlog[j] != 16'(32'h1000 + j)) bad++;
        chk("start_ignored_bad", 32'(bad), 32'd0);
        @(posedge clk); #2 resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_cmd",  32'(cmd[0]),  32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_done", 32'(done[0]), 32'd0);
        #5 resetn = 1'b1;
        repeat (2) @(negedge clk);
        wlog.delete();
        pulse_start(0, 2'd0, 16'h1000, 23'h0);
        wait_done(0, n);
        chk("rerun_done", 32'(done[0]), 32'd1);
        chk("rerun_pass", 32'(pass[0]), 32'd1);
        chk("rerun_err",  32'(errc[0]), 32'd0);
        chk("rerun_first", (wlog.size() > 0) ? 32'(wlog[0]) : 32'hFFFF_FFFF, 32'h1000);
        chk("cmd_hold_violations", 32'(hold_err), 32'd0);

`ifdef SDRAM_BURST_TESTER_TIMEOUT_EN
        noack[0] = 1;
        pulse_start(0, 2'd0, 16'h1234, 23'h0);
        wait_done(0, n);
        chk("to_flag",   32'(tmo[0]),  32'd1);
        chk("to_done",   32'(done[0]), 32'd1);
        chk("to_pass",   32'(pass[0]), 32'd0);
        chk("to_cmd",    32'(cmd[0]),  32'd0);
        chk("to_cycles", 32'(n >= 4090 && n <= 4105), 32'd1);
        noack[0] = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, limit 3000000 reached");
        $fatal(1);
    end

endmodule
